// File: rtl/lc3_mem_arbiter.sv
// Arbiter sharing one off-chip memory port between the LC3 instruction and data caches.
// Define ARB_RR_EN to let a waiting instruction read win once after each data transaction.
module lc3_mem_arbiter #(
    parameter int BLOCK_WORDS = 4,
    parameter int CW          = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          i_rrqst,
    input  logic [15:0]   i_addr,
    output logic          i_rdacpt,
    output logic          i_rdrdy,
    input  logic          d_rrqst,
    input  logic          d_wrqst,
    input  logic [15:0]   d_addr,
    input  logic [15:0]   d_din,
    output logic          d_rdacpt,
    output logic          d_wacpt,
    output logic          d_rdrdy,
    output logic [15:0]   rdata,
    output logic [CW-1:0] count,
    output logic          mem_req,
    output logic          mem_rd,
    output logic [15:0]   mem_addr,
    output logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout,
    input  logic          mem_rrdy,
    input  logic          mem_wacpt,
    output logic          busy
);

    typedef enum logic [1:0] {IDLE, I_RD, D_RD, D_WR} arbState;

    localparam logic [15:0]   ALIGN_MASK = ~16'(BLOCK_WORDS - 1);
    localparam logic [CW-1:0] LAST_WORD  = CW'(BLOCK_WORDS - 1);

    arbState       state, stateNext;
    logic [CW-1:0] counter, counterNext;
    logic [CW-1:0] countNext;
    logic [15:0]   rdataNext, memAddrNext, memDinNext;
    logic          memReqNext, memRdNext;
    logic          iRdacptNext, dRdacptNext, dWacptNext, iRdrdyNext, dRdrdyNext;
    logic          iFirst;
`ifdef ARB_RR_EN
    logic          rrFlag, rrNext;
`endif

    assign busy = (state != IDLE);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        stateNext   = state;
        counterNext = counter;
        countNext   = count;
        rdataNext   = rdata;
        memReqNext  = mem_req;
        memRdNext   = mem_rd;
        memAddrNext = mem_addr;
        memDinNext  = mem_din;
        iRdacptNext = 1'b0;
        dRdacptNext = 1'b0;
        dWacptNext  = 1'b0;
        iRdrdyNext  = 1'b0;
        dRdrdyNext  = 1'b0;
`ifdef ARB_RR_EN
        rrNext      = rrFlag;
        iFirst      = rrFlag && i_rrqst;
`else
        iFirst      = 1'b0;
`endif

        case (state)
            IDLE: begin
                counterNext = '0;
                // Writes drain ahead of refills so write-through ordering holds.
                if (iFirst || (i_rrqst && !d_wrqst && !d_rrqst)) begin
                    stateNext   = I_RD;
                    memReqNext  = 1'b1;
                    memRdNext   = 1'b1;
                    memAddrNext = i_addr & ALIGN_MASK;
                    iRdacptNext = 1'b1;
                end else if (d_wrqst) begin
                    stateNext   = D_WR;
                    memReqNext  = 1'b1;
                    memRdNext   = 1'b0;
                    memAddrNext = d_addr;
                    memDinNext  = d_din;
                end else if (d_rrqst) begin
                    stateNext   = D_RD;
                    memReqNext  = 1'b1;
                    memRdNext   = 1'b1;
                    memAddrNext = d_addr & ALIGN_MASK;
                    dRdacptNext = 1'b1;
                end
            end

            I_RD, D_RD: begin
                if (mem_rrdy) begin
                    rdataNext   = mem_dout;
                    countNext   = counter;
                    iRdrdyNext  = (state == I_RD);
                    dRdrdyNext  = (state == D_RD);
                    counterNext = counter + CW'(1);
                    if (counter == LAST_WORD) begin
                        counterNext = '0;
                        memReqNext  = 1'b0;
                        stateNext   = IDLE;
`ifdef ARB_RR_EN
                        rrNext      = (state == D_RD);
`endif
                    end
                end
            end

            D_WR: begin
                if (mem_wacpt) begin
                    dWacptNext = 1'b1;
                    memReqNext = 1'b0;
                    stateNext  = IDLE;
`ifdef ARB_RR_EN
                    rrNext     = 1'b1;
`endif
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            counter  <= '0;
            count    <= '0;
            rdata    <= '0;
            mem_req  <= 1'b0;
            mem_rd   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            i_rdacpt <= 1'b0;
            d_rdacpt <= 1'b0;
            d_wacpt  <= 1'b0;
            i_rdrdy  <= 1'b0;
            d_rdrdy  <= 1'b0;
`ifdef ARB_RR_EN
            rrFlag   <= 1'b0;
`endif
        end else begin
            state    <= stateNext;
            counter  <= counterNext;
            count    <= countNext;
            rdata    <= rdataNext;
            mem_req  <= memReqNext;
            mem_rd   <= memRdNext;
            mem_addr <= memAddrNext;
            mem_din  <= memDinNext;
            i_rdacpt <= iRdacptNext;
            d_rdacpt <= dRdacptNext;
            d_wacpt  <= dWacptNext;
            i_rdrdy  <= iRdrdyNext;
            d_rdrdy  <= dRdrdyNext;
`ifdef ARB_RR_EN
            rrFlag   <= rrNext;
`endif
        end
    end

endmodule
